// File: rtl/mux8_4to1_rr_pkg.sv
// Shared definitions for the 4-to-1 merge and its 1-to-4 demux counterpart:
// channel count, default width, Sel encodings and a lowest-index priority encoder.
package mux8_4to1_rr_pkg;

   localparam int NUM_CH    = 4;
   localparam int DEF_WIDTH = 8;

   localparam logic [1:0] SEL_W = 2'd0;
   localparam logic [1:0] SEL_X = 2'd1;
   localparam logic [1:0] SEL_Y = 2'd2;
   localparam logic [1:0] SEL_Z = 2'd3;

   // Index of the lowest set bit; also converts a one-hot vector to its index.
   function automatic logic [1:0] prio_idx(input logic [NUM_CH-1:0] req);
      logic [1:0] idx_s;
      casez (req)
         4'b???1: idx_s = SEL_W;
         4'b??10: idx_s = SEL_X;
         4'b?100: idx_s = SEL_Y;
         4'b1000: idx_s = SEL_Z;
         default: idx_s = SEL_W;
      endcase
      return idx_s;
   endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-way arbiter with one-hot grant. MUX8_RR_EN selects round-robin with a
// last-grant pointer; without it the policy is fixed priority W>X>Y>Z.
module rr_arb4
   import mux8_4to1_rr_pkg::*;
(
`ifdef MUX8_RR_EN
   input  logic              clk,
   input  logic              rst,
`endif
   input  logic [NUM_CH-1:0] req,
   input  logic              en,
   output logic [NUM_CH-1:0] gnt
);

   logic [1:0] idx_s;
   logic       any_s;

   // Any source requesting at all
   always_comb begin
      any_s = |req;
   end

`ifdef MUX8_RR_EN
   logic [1:0] last_r;
   logic [1:0] start_s;
   logic [7:0] dbl_s;
   logic [3:0] rot_s;

   // Rotate requests so the source after the last grant sits at bit 0
   always_comb begin
      start_s = last_r + 2'd1;
      dbl_s   = {req, req};
      rot_s   = dbl_s[start_s +: 4];
      idx_s   = start_s + prio_idx(rot_s);
   end

   // Pointer moves only when a grant is actually taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_r <= SEL_Z;
      end else if (en && any_s) begin
         last_r <= idx_s;
      end else begin
         last_r <= last_r;
      end
   end
`else
   // Fixed priority, lowest index wins
   always_comb begin
      idx_s = prio_idx(req);
   end
`endif

   // One-hot grant, only to a requester and only while enabled
   always_comb begin
      gnt = 4'b0000;
      if (en && any_s) begin
         gnt[idx_s] = 1'b1;
      end else begin
         gnt = 4'b0000;
      end
   end

endmodule

// File: rtl/mux8_4to1_rr.sv
// Four-source valid/ready merge into one registered output word with its Sel tag.
// Arbitration policy chosen by MUX8_RR_EN (round-robin) or fixed priority otherwise.
module mux8_4to1_rr
   import mux8_4to1_rr_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] W,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic [WIDTH-1:0] Z,
   input  logic [3:0]       in_valid,
   output logic [3:0]       in_ready,
   output logic [WIDTH-1:0] A,
   output logic [1:0]       Sel,
   output logic             out_valid,
   input  logic             out_ready
);

   logic             load_s;
   logic             arb_en_s;
   logic [3:0]       gnt_s;
   logic [1:0]       gidx_s;
   logic [WIDTH-1:0] gdata_s;

   // Output register is free or being drained; grants are blocked during reset
   always_comb begin
      load_s   = !out_valid || out_ready;
      arb_en_s = load_s && !rst;
   end

   rr_arb4 u_arb (
`ifdef MUX8_RR_EN
      .clk (clk),
      .rst (rst),
`endif
      .req (in_valid),
      .en  (arb_en_s),
      .gnt (gnt_s)
   );

   // Granted source index and its data
   always_comb begin
      in_ready = gnt_s;
      gidx_s   = prio_idx(gnt_s);
      case (gidx_s)
         SEL_W:   gdata_s = W;
         SEL_X:   gdata_s = X;
         SEL_Y:   gdata_s = Y;
         SEL_Z:   gdata_s = Z;
         default: gdata_s = W;
      endcase
   end

   // Output register: load on a transfer, empty when free with no requester
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         A         <= '0;
         Sel       <= SEL_W;
      end else if (load_s && (|gnt_s)) begin
         out_valid <= 1'b1;
         A         <= gdata_s;
         Sel       <= gidx_s;
      end else if (load_s) begin
         out_valid <= 1'b0;
         A         <= A;
         Sel       <= Sel;
      end else begin
         out_valid <= out_valid;
         A         <= A;
         Sel       <= Sel;
      end
   end

endmodule

// File: doc/mux8_4to1_rr.md
MUX8_4TO1_RR -- requirements
Module: mux8_4to1_rr

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width of every channel and of the output.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: W, X, Y, Z  input  WIDTH each  channel data for sources 0..3.
REQ-005 SHALL have port: in_valid  input  4  per-source valid; bit0=W, bit1=X, bit2=Y, bit3=Z.
REQ-006 SHALL have port: in_ready  output  4  per-source ready, same bit order.
REQ-007 SHALL have port: A  output  WIDTH  merged output data.
REQ-008 SHALL have port: Sel  output  2  source index of A (W=00, X=01, Y=10, Z=11).
REQ-009 SHALL have port: out_valid  output  1  A/Sel hold a word.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts A when high with out_valid.

Function
REQ-011 SHALL define load = !out_valid || out_ready (output register free or draining this cycle).
REQ-012 SHALL raise in_ready[i] only when load is high and source i holds the grant; at most one bit high per cycle; combinational from in_valid, out_valid, out_ready and arbitration state.
REQ-013 SHALL treat a source transfer as in_valid[i] && in_ready[i]; on that edge A <= channel i data, Sel <= i, out_valid <= 1.
REQ-014 SHALL, when load is high and no in_valid bit set, clear out_valid on the edge; A and Sel hold their last values.
REQ-015 SHALL, when out_valid && !out_ready, hold A, Sel, out_valid stable and drive in_ready to 0000.
REQ-016 SHALL give one-cycle latency: data accepted at edge N appears on A at edge N; sustains one word per cycle when out_ready stays high.
REQ-017 SHALL arbitrate round-robin: search order starts at the source after the last granted one, wrapping Z->W; pointer advances only on an actual transfer.
REQ-018 SHALL not drop or duplicate words: each input transfer yields exactly one output transfer, in grant order.
REQ-019 SHALL grant a lone requester in the same cycle regardless of pointer position.
REQ-020 SHALL accept a new source word in the same cycle the held word is drained (simultaneous out transfer and in transfer).

Reset
REQ-021 SHALL on rst asynchronously force out_valid=0, A=0, Sel=00, in_ready=0000, last-grant pointer=Z (so W searched first).
REQ-022 SHALL discard any held word when rst asserts mid-operation; no output transfer is produced for it.
REQ-023 SHALL resume arbitration on the first rising edge after rst deasserts.

Configuration
REQ-024 SHALL, with MUX8_RR_EN defined, arbitrate round-robin per REQ-017.
REQ-025 SHALL, without MUX8_RR_EN, use fixed priority W>X>Y>Z; pointer logic removed; all other requirements unchanged.

Structure
REQ-026 SHALL take from shared package: channel count 4, default width 8, Sel encodings SEL_W=0, SEL_X=1, SEL_Y=2, SEL_Z=3 (shared with the 1-to-4 demux).
REQ-027 SHALL place arbitration in sub-module rr_arb4 (4-bit request, enable, one-hot grant, internal pointer, macro-selected policy).
REQ-028 SHALL keep the output register and handshake in mux8_4to1_rr top.

Verification
REQ-029 SHALL cover: reset, then in_valid=0001, W=8'hA5, out_ready=1 -> in_ready=0001; next edge A=A5, Sel=00, out_valid=1.
REQ-030 SHALL cover: all four valid continuously, W/X/Y/Z=11/22/33/44, out_ready=1 -> Sel sequence 00,01,10,11,00 and A 11,22,33,44,11 (RR_EN); without macro A stays 11.
REQ-031 SHALL cover: word held, out_ready=0 for 3 cycles -> A, Sel, out_valid unchanged, in_ready=0000; out_ready=1 -> next word loads that edge.
REQ-032 SHALL cover: only Z valid (8'hFF) after W granted -> Z granted immediately, A=FF, Sel=11.
REQ-033 SHALL cover: rst pulsed while out_valid=1, A=8'h5A -> out_valid=0, A=00, Sel=00 without clock edge; first grant after release goes to W.
REQ-034 SHALL cover: in_valid drops to 0000 with out_ready=1 -> out_valid=0 next edge, A/Sel hold last values.
